block_accum: RTL and testbench

BLOCK_ACCUM -- requirements
Module: block_accum

---
 rtl/block_accum.sv | 139 +++++++++++++
 tb/tb_block_accum.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/block_accum.sv
// Block accumulator: sums dv-qualified samples into blocks of block_len (or until flush)
// and emits one registered result per block with sample count and a sticky wrap flag.
//   state | meaning
//   IDLE  | no samples held; next dv starts a block and latches its length
//   ACCUM | 1..len-1 samples held in acc/count
module block_accum #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dv,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  block_len,
  input  logic              flush,
  output logic [ACC_W-1:0]  data_out,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              ovf_out,
  output logic              dv_out
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              sticky_q, sticky_d;
  logic [ACC_W-1:0]  data_out_q, data_out_d;
  logic [CNT_W-1:0]  cnt_out_q, cnt_out_d;
  logic              ovf_out_q, ovf_out_d;
  logic              dv_out_q, dv_out_d;

  logic              in_idle;
  logic [ACC_W:0]    data_ext;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_base;
  logic [CNT_W-1:0]  cnt_base;
  logic              sticky_base;
  logic [CNT_W-1:0]  cnt_next;
  logic              sticky_next;
  logic [CNT_W-1:0]  len_eff;
  logic              emit;
  logic [ACC_W-1:0]  acc_fin;
  logic [CNT_W-1:0]  cnt_fin;
  logic              ovf_fin;

  // Datapath operands: a sample taken in IDLE starts from an empty block.
  always_comb begin
    in_idle                 = (state_q == IDLE);
    data_ext                = '0;
    data_ext[DATA_W-1:0]    = data_in;
    acc_base                = in_idle ? '0 : acc_q;
    cnt_base                = in_idle ? '0 : count_q;
    sticky_base             = in_idle ? 1'b0 : sticky_q;
    len_eff                 = len_q;
    if (in_idle) begin
      len_eff = (block_len == '0) ? CNT_W'(1) : block_len;
    end
    sum         = {1'b0, acc_base} + data_ext;
    cnt_next    = cnt_base + CNT_W'(1);
    sticky_next = sticky_base | sum[ACC_W];
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    acc_d      = acc_q;
    sticky_d   = sticky_q;
    data_out_d = data_out_q;
    cnt_out_d  = cnt_out_q;
    ovf_out_d  = ovf_out_q;
    dv_out_d   = 1'b0;
    emit       = 1'b0;
    acc_fin    = acc_q;
    cnt_fin    = count_q;
    ovf_fin    = sticky_q;

    if (dv) begin
      acc_fin = sum[ACC_W-1:0];
      cnt_fin = cnt_next;
      ovf_fin = sticky_next;
      emit    = (cnt_next == len_eff) || flush;
      if (!emit) begin
        state_d  = ACCUM;
        len_d    = len_eff;
        acc_d    = acc_fin;
        count_d  = cnt_fin;
        sticky_d = ovf_fin;
      end
    end else if (flush && !in_idle) begin
      emit = 1'b1;
    end

    // Emission clears the block in the same edge so the next cycle's dv starts fresh.
    if (emit) begin
      data_out_d = acc_fin;
      cnt_out_d  = cnt_fin;
      ovf_out_d  = ovf_fin;
      dv_out_d   = 1'b1;
      state_d    = IDLE;
      acc_d      = '0;
      count_d    = '0;
      sticky_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      count_q    <= '0;
      acc_q      <= '0;
      sticky_q   <= 1'b0;
      data_out_q <= '0;
      cnt_out_q  <= '0;
      ovf_out_q  <= 1'b0;
      dv_out_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      sticky_q   <= sticky_d;
      data_out_q <= data_out_d;
      cnt_out_q  <= cnt_out_d;
      ovf_out_q  <= ovf_out_d;
      dv_out_q   <= dv_out_d;
    end
  end

  assign data_out = data_out_q;
  assign cnt_out  = cnt_out_q;
  assign ovf_out  = ovf_out_q;
  assign dv_out   = dv_out_q;

endmodule

// File: tb/tb_block_accum.sv
// Scoreboard bench for block_accum: default-width instance plus a 32/32 instance for wrap cases.
module tb_block_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        dv, flush;
  logic [31:0] data_in;
  logic [7:0]  block_len;
  logic [39:0] data_out;
  logic [7:0]  cnt_out;
  logic        ovf_out, dv_out;

  logic        dv32, flush32;
  logic [31:0] data32;
  logic [7:0]  bl32;
  logic [31:0] data_out32;
  logic [7:0]  cnt_out32;
  logic        ovf_out32, dv_out32;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] d;
    logic [63:0] c;
    logic        o;
    int          cy;
  } exp_t;

  exp_t q[$];
  exp_t q32[$];

  block_accum dut (
    .clk(clk), .reset(reset), .dv(dv), .data_in(data_in), .block_len(block_len),
    .flush(flush), .data_out(data_out), .cnt_out(cnt_out), .ovf_out(ovf_out), .dv_out(dv_out)
  );

  block_accum #(.DATA_W(32), .ACC_W(32), .CNT_W(8)) dut32 (
    .clk(clk), .reset(reset), .dv(dv32), .data_in(data32), .block_len(bl32),
    .flush(flush32), .data_out(data_out32), .cnt_out(cnt_out32), .ovf_out(ovf_out32),
    .dv_out(dv_out32)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected result appears one cycle after the sample presented by the next drv call.
  task automatic push(input logic [63:0] d, input logic [63:0] c, input logic o);
    exp_t e;
    e.d = d; e.c = c; e.o = o; e.cy = cyc + 1;
    q.push_back(e);
  endtask

  task automatic push32(input logic [63:0] d, input logic [63:0] c, input logic o);
    exp_t e;
    e.d = d; e.c = c; e.o = o; e.cy = cyc + 1;
    q32.push_back(e);
  endtask

  task automatic drv(input logic v, input logic [31:0] d, input logic f);
    dv = v; data_in = d; flush = f;
    @(posedge clk); #1;
    dv = 1'b0; flush = 1'b0;
  endtask

  task automatic drv32(input logic v, input logic [31:0] d);
    dv32 = v; data32 = d;
    @(posedge clk); #1;
    dv32 = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (dv_out) begin
      if (q.size() == 0) check("unexpected_dv_out", 64'(dv_out), 64'd0);
      else begin
        e = q.pop_front();
        check("data_out", 64'(data_out), e.d);
        check("cnt_out", 64'(cnt_out), e.c);
        check("ovf_out", 64'(ovf_out), 64'(e.o));
        check("latency", 64'(cyc), 64'(e.cy));
      end
    end
    if (dv_out32) begin
      if (q32.size() == 0) check("unexpected_dv_out32", 64'(dv_out32), 64'd0);
      else begin
        e = q32.pop_front();
        check("data_out32", 64'(data_out32), e.d);
        check("cnt_out32", 64'(cnt_out32), e.c);
        check("ovf_out32", 64'(ovf_out32), 64'(e.o));
        check("latency32", 64'(cyc), 64'(e.cy));
      end
    end
  end

  initial begin
    reset = 1'b1; dv = 0; flush = 0; data_in = 0; block_len = 8'd4;
    dv32 = 0; flush32 = 0; data32 = 0; bl32 = 8'd2;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_cnt_out", 64'(cnt_out), 64'd0);
    check("rst_ovf_out", 64'(ovf_out), 64'd0);
    check("rst_dv_out", 64'(dv_out), 64'd0);

    // block of 4: 1+2+3+4
    block_len = 8'd4;
    drv(1, 1, 0); drv(1, 2, 0); drv(1, 3, 0);
    push(10, 4, 0); drv(1, 4, 0);
    repeat (2) drv(0, 0, 0);

    // block of 2, continuous stream
    block_len = 8'd2;
    drv(1, 5, 0); push(11, 2, 0); drv(1, 6, 0);
    drv(1, 7, 0); push(15, 2, 0); drv(1, 8, 0);
    repeat (2) drv(0, 0, 0);

    // flush of a partial block, then flush while idle
    block_len = 8'd8;
    drv(1, 100, 0); drv(1, 200, 0); drv(1, 300, 0);
    push(600, 3, 0); drv(0, 0, 1);
    repeat (3) drv(0, 0, 1);
    check("hold_after_idle_flush", 64'(data_out), 64'd600);

    // flush on the same cycle as a sample includes that sample
    drv(1, 7, 0); push(10, 2, 0); drv(1, 3, 1);
    drv(0, 0, 0);

    // block_len 0 behaves as 1
    block_len = 8'd0;
    push(9, 1, 0); drv(1, 9, 0);
    push(9, 1, 0); drv(1, 9, 0);
    drv(0, 0, 0);

    // length change mid-block applies only to the next block
    block_len = 8'd4;
    drv(1, 1, 0);
    block_len = 8'd2;
    drv(1, 2, 0); drv(1, 3, 0);
    push(10, 4, 0); drv(1, 4, 0);
    drv(1, 1, 0); push(3, 2, 0); drv(1, 2, 0);
    drv(0, 0, 0);

    // reset discards a partial block; first post-reset cycle accepts dv
    block_len = 8'd4;
    drv(1, 50, 0); drv(1, 60, 0);
    reset = 1'b1; drv(0, 0, 0); reset = 1'b0;
    check("rst2_data_out", 64'(data_out), 64'd0);
    check("rst2_cnt_out", 64'(cnt_out), 64'd0);
    check("rst2_dv_out", 64'(dv_out), 64'd0);
    drv(1, 1, 0); drv(1, 1, 0); drv(1, 1, 0);
    push(4, 4, 0); drv(1, 1, 0);
    repeat (4) drv(0, 0, 0);
    check("hold_data_out", 64'(data_out), 64'd4);
    check("hold_cnt_out", 64'(cnt_out), 64'd4);

    // 32-bit accumulator wrap on the second instance
    bl32 = 8'd2;
    drv32(1, 32'hFFFF_FFFF); push32(1, 2, 1); drv32(1, 32'h0000_0002);
    drv32(1, 1); push32(2, 2, 0); drv32(1, 1);
    repeat (3) drv32(0, 0);
    check("hold_ovf_out32", 64'(ovf_out32), 64'd0);

    check("sb_empty", 64'(q.size()), 64'd0);
    check("sb32_empty", 64'(q32.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
